cordic_angle_prep: RTL and testbench
====================================

Name: cordic_angle_prep

Overview:
Upstream feeder for cos_cordic. It converts an IEEE-754 single-precision sample x into the signed fixed-point CORDIC angle θ = (x − 128)/128, in Q2.30.
- Uses the same custom-instruction handshake as cos_cordic (start/done, clk_en), so the host or a sequencer can chain its result straight into cos_cordic's dataa.
- Multi-cycle, non-pipelined: one conversion in flight at a time.

Parameters:
- FRAC_BITS, 30, fractional bits of the output fixed-point format (Q2.FRAC_BITS, 32-bit total).
- EXP_SCALE, 7, divisor exponent (x / 2^EXP_SCALE).
- OFFSET, 32'h40000000, fixed-point constant subtracted after scaling (1.0 in Q2.30).

Ports:
- clk  in  1  system clock.
- aclr  in  1  asynchronous reset, active-low (asserted at 0).
- clk_en  in  1  clock enable; when 0, all state and outputs hold.
- start  in  1  request; sampled on a rising clk edge with clk_en=1.
- dataa  in  32  IEEE-754 single x; sampled together with start.
- result  out  32  signed Q2.30 angle θ.
- done  out  1  one-cycle pulse: result is valid.
- busy  out  1  high while a conversion is in flight.
- sat  out  1  set with done when the output was saturated or the input was NaN/Inf.

Behaviour:
- Reset (aclr=0, asynchronous): state=IDLE, result=0, done=0, busy=0, sat=0.
  - Reset taking effect mid-conversion aborts it; no done is produced.
  - After release, the block waits for a new start.
- FSM states IDLE → UNPACK → SHIFT → FINISH → IDLE. It advances only on edges with clk_en=1.
- IDLE:
  - On start=1, latch dataa and go to UNPACK; busy=1 from the next cycle.
  - start while busy=1 is ignored; the latched operand is not disturbed.
- UNPACK:
  - Split the latched operand into s, e[7:0] and M = {1, frac[22:0]} (24 bits).
  - Compute k = e − 127 − 23 − EXP_SCALE + FRAC_BITS; with defaults, k = e − 127.
  - Classify the input:
    - e=0 (zero or denormal): F=0.
    - e=255 with frac≠0 (NaN): result=0, sat=1.
    - e=255 with frac=0 (±Inf): saturate by sign, sat=1.
    - k > 7 (|x| ≥ 256 with defaults): saturate by sign, sat=1.
- SHIFT:
  - k ≥ 0: F = M << k. k < 0: F = M >> −k, truncating toward zero.
  - −k > 24 gives F=0.
  - Apply the sign: F = s ? −F : F, held in a 34-bit signed intermediate.
- FINISH:
  - D = F − OFFSET, computed in 34 bits.
  - Clamp D to [32'h80000000, 32'h7FFFFFFF]. Any clamp sets sat=1.
  - Register result=D[31:0] and assert done=1 for this one cycle; busy=0 on the next cycle.
- Latency: start is accepted on edge N; done is high in the cycle following edge N+3 (3 enabled cycles).
  - With clk_en toggling, latency is counted in enabled edges only.
  - done stays high while clk_en=0, then drops on the next enabled edge.
- result and sat hold their values until the next FINISH. done is never high in two consecutive enabled cycles.
- start asserted in the same cycle done is high is accepted: back-to-back issue is allowed.

Decomposition:
- Shared package cordic_pkg:
  - FP32 field widths and positions, EXP_BIAS=127.
  - Q2.30 constants: ONE=32'h40000000, MAX=32'h7FFFFFFF, MIN=32'h80000000.
  - Typedef for the unpacked float {sign, exp, mant24}.
  - FSM state encoding.
- One sub-module, fx_shift_sat: combinational bidirectional barrel shift plus sign apply and clamp. It is reused later by the downstream fixed-to-float stage.

Test Plan:
- dataa=32'h43000000 (128.0), start pulse → done exactly 3 enabled cycles later, result=32'h00000000, sat=0.
- dataa=32'h437F0000 (255.0) → result=32'h3F800000. dataa=32'h42800000 (64.0) → result=32'hE0000000. dataa=32'h00000000 (0.0) → result=32'hC0000000. All with sat=0.
- dataa=32'h447A0000 (1000.0) → result=32'h7FFFFFFF, sat=1. dataa=32'hC3960000 (−300.0) → result=32'h80000000, sat=1. dataa=32'h7FC00000 (NaN) → result=0, sat=1.
- Start 128.0, then assert start with 64.0 at cycle 1 (busy) → that start is ignored; a single done with result=0. Then start 64.0 in the done cycle → second done 3 cycles later, result=32'hE0000000.
- Drive clk_en=0 for 5 cycles during SHIFT → no state change; done arrives 5 cycles later than nominal; result correct.
- Drive aclr=0 asynchronously between clock edges during UNPACK → result, done, busy and sat are 0 immediately. After release, no done appears until a new start.

Source files
------------

// File: rtl/cordic_pkg.sv
// ============================================================================
// cordic_pkg -- FP32 field layout, Q2.30 constants and FSM encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cordic_pkg;

  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;
  localparam int FP_EXP_LSB = 23;
  localparam int FP_SIGN_POS = 31;
  localparam int EXP_BIAS  = 127;

  localparam logic [31:0] Q_ONE = 32'h4000_0000;
  localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN = 32'h8000_0000;

  // Largest left shift of the 24-bit mantissa that still fits a signed 32-bit word.
  localparam logic signed [9:0] Q_K_MAX = 10'sd7;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W:0]   mant;
  } fp_unpacked_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UNPACK = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_NAN  = 2'd2;
  localparam logic [1:0] CLS_SAT  = 2'd3;

  function automatic fp_unpacked_t unpack_fp(input logic [31:0] w);
    fp_unpacked_t f;
    f.sign = w[FP_SIGN_POS];
    f.exp  = w[FP_EXP_LSB +: FP_EXP_W];
    f.mant = {(w[FP_EXP_LSB +: FP_EXP_W] != '0), w[FP_MANT_W-1:0]};
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fx_shift_sat.sv
// ============================================================================
// fx_shift_sat -- bidirectional barrel shift with sign apply, plus signed clamp.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fx_shift_sat #(
  parameter int IN_W  = 24,
  parameter int ACC_W = 34,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]          mag,
  input  logic signed [9:0]        shamt,
  input  logic                     neg,
  output logic signed [ACC_W-1:0]  shifted,
  input  logic signed [ACC_W-1:0]  acc,
  output logic [OUT_W-1:0]         clamped,
  output logic                     clamp_hit
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [9:0]              IN_W_V  = 10'(IN_W);

  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_mag;
  logic [9:0]       w_amt;

  always_comb begin
    w_ext = {{(ACC_W-IN_W){1'b0}}, mag};
    w_amt = '0;
    w_mag = '0;
    if (!shamt[9]) begin
      w_amt = $unsigned(shamt);
      w_mag = w_ext << w_amt;
    end else begin
      w_amt = $unsigned(-shamt);
      // Right shifts truncate toward zero because the sign is applied afterwards.
      w_mag = (w_amt >= IN_W_V) ? '0 : (w_ext >> w_amt);
    end
    shifted = neg ? -$signed(w_mag) : $signed(w_mag);
  end

  always_comb begin
    clamp_hit = 1'b0;
    clamped   = acc[OUT_W-1:0];
    if (acc > SAT_MAX) begin
      clamped   = SAT_MAX[OUT_W-1:0];
      clamp_hit = 1'b1;
    end else if (acc < SAT_MIN) begin
      clamped   = SAT_MIN[OUT_W-1:0];
      clamp_hit = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cordic_angle_prep.sv
// ============================================================================
// cordic_angle_prep -- converts FP32 x into Q2.30 angle (x - 128)/128.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cordic_angle_prep
  import cordic_pkg::*;
#(
  parameter int          FRAC_BITS = 30,
  parameter int          EXP_SCALE = 7,
  parameter logic [31:0] OFFSET    = Q_ONE
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        sat
);

  localparam logic signed [9:0]  K_ADJ      = 10'(EXP_BIAS + FP_MANT_W + EXP_SCALE - FRAC_BITS);
  localparam logic signed [33:0] OFFSET_EXT = {{2{OFFSET[31]}}, OFFSET};

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [31:0]        r_operand;
  logic               r_sign;
  logic [23:0]        r_mant;
  logic signed [9:0]  r_k;
  logic [1:0]         r_class;
  logic signed [33:0] r_f;

  logic               w_load;
  logic               w_do_unpack;
  logic               w_do_shift;
  logic               w_do_finish;
  logic               w_done_nxt;
  logic               w_busy_nxt;

  fp_unpacked_t       w_fp;
  logic signed [9:0]  w_k;
  logic [1:0]         w_class;
  logic signed [33:0] w_shifted;
  logic signed [33:0] w_d;
  logic [31:0]        w_clamped;
  logic               w_clamp_hit;
  logic [31:0]        w_res_nxt;
  logic               w_sat_nxt;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state <= ST_IDLE;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_UNPACK;
      ST_UNPACK: w_state_nxt = ST_SHIFT;
      ST_SHIFT:  w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load      = (r_state == ST_IDLE) && start;
    w_do_unpack = (r_state == ST_UNPACK);
    w_do_shift  = (r_state == ST_SHIFT);
    w_do_finish = (r_state == ST_FINISH);
    w_done_nxt  = w_do_finish;
    // busy drops together with the done pulse so a start in that cycle is taken.
    w_busy_nxt  = (r_state == ST_IDLE) ? start : !w_do_finish;
  end

  always_comb begin
    w_fp    = unpack_fp(r_operand);
    w_k     = $signed({2'b00, w_fp.exp}) - K_ADJ;
    w_class = CLS_NORM;
    if (w_fp.exp == '0) begin
      w_class = CLS_ZERO;
    end else if (w_fp.exp == '1) begin
      w_class = (w_fp.mant[FP_MANT_W-1:0] != '0) ? CLS_NAN : CLS_SAT;
    end else if (w_k > Q_K_MAX) begin
      w_class = CLS_SAT;
    end
  end

  assign w_d = r_f - OFFSET_EXT;

  fx_shift_sat #(
    .IN_W  (24),
    .ACC_W (34),
    .OUT_W (32)
  ) u_shift_sat (
    .mag       (r_mant),
    .shamt     (r_k),
    .neg       (r_sign),
    .shifted   (w_shifted),
    .acc       (w_d),
    .clamped   (w_clamped),
    .clamp_hit (w_clamp_hit)
  );

  always_comb begin
    w_res_nxt = w_clamped;
    w_sat_nxt = w_clamp_hit;
    case (r_class)
      CLS_NAN: begin
        w_res_nxt = '0;
        w_sat_nxt = 1'b1;
      end
      CLS_SAT: begin
        w_res_nxt = r_sign ? Q_MIN : Q_MAX;
        w_sat_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      sat       <= 1'b0;
      r_operand <= '0;
      r_sign    <= 1'b0;
      r_mant    <= '0;
      r_k       <= '0;
      r_class   <= CLS_ZERO;
      r_f       <= '0;
    end else if (clk_en) begin
      done <= w_done_nxt;
      busy <= w_busy_nxt;
      if (w_load) begin
        r_operand <= dataa;
      end
      if (w_do_unpack) begin
        r_sign  <= w_fp.sign;
        r_mant  <= w_fp.mant;
        r_k     <= w_k;
        r_class <= w_class;
      end
      if (w_do_shift) begin
        r_f <= (r_class == CLS_NORM) ? w_shifted : '0;
      end
      if (w_do_finish) begin
        result <= w_res_nxt;
        sat    <= w_sat_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_angle_prep.sv
// ============================================================================
// tb_cordic_angle_prep -- scoreboard bench for the FP32-to-Q2.30 angle feeder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cordic_angle_prep;

  logic        clk = 1'b0;
  logic        aclr = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        sat;

  typedef struct {
    logic [31:0] res;
    logic        sat;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t item;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;
  logic rise;
  logic final_req = 1'b0;

  cordic_angle_prep dut (
    .clk    (clk),
    .aclr   (aclr),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done),
    .busy   (busy),
    .sat    (sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk or negedge aclr) begin
    if (!aclr) begin
      #1;
      check("rst_result", result, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_sat", {31'b0, sat}, 32'h0);
      sb.delete();
      prev_done <= 1'b0;
    end else begin
      rise = done && !prev_done;
      check("busy", {31'b0, busy}, {31'b0, (sb.size() != 0) && !rise});
      if (rise) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'h1, 32'h0);
        end else begin
          item = sb.pop_front();
          check("result", result, item.res);
          check("sat", {31'b0, sat}, {31'b0, item.sat});
          check("latency", 32'(cyc), 32'(item.due));
        end
      end
      if (final_req) begin
        check("drain", 32'(sb.size()), 32'h0);
        final_req <= 1'b0;
      end
      prev_done <= done;
    end
  end

  // Call positioned just after a negedge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] d, input logic [31:0] er, input logic es,
                       input int extra, input bit push);
    start = 1'b1;
    dataa = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) sb.push_back('{er, es, cyc + 3 + extra});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
  endtask

  task automatic wait_done_cycle();
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
  endtask

  initial begin
    #2 aclr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    aclr = 1'b1;
    repeat (2) @(negedge clk);

    issue(32'h4300_0000, 32'h0000_0000, 1'b0, 0, 1'b1);  // 128.0
    wait_idle(); @(negedge clk);
    issue(32'h437F_0000, 32'h3F80_0000, 1'b0, 0, 1'b1);  // 255.0
    wait_idle(); @(negedge clk);
    issue(32'h4280_0000, 32'hE000_0000, 1'b0, 0, 1'b1);  // 64.0
    wait_idle(); @(negedge clk);
    issue(32'h0000_0000, 32'hC000_0000, 1'b0, 0, 1'b1);  // 0.0
    wait_idle(); @(negedge clk);
    issue(32'hC396_0000, 32'h8000_0000, 1'b1, 0, 1'b1);  // -300.0
    wait_idle(); @(negedge clk);
    issue(32'h7FC0_0000, 32'h0000_0000, 1'b1, 0, 1'b1);  // NaN
    wait_idle(); @(negedge clk);
    issue(32'hFF80_0000, 32'h8000_0000, 1'b1, 0, 1'b1);  // -Inf
    wait_idle(); @(negedge clk);
    issue(32'h3F80_0000, 32'hC080_0000, 1'b0, 0, 1'b1);  // 1.0 -> -127/128
    wait_idle(); @(negedge clk);

    // Start while busy is ignored, then back-to-back issue in the done cycle.
    issue(32'h4300_0000, 32'h0000_0000, 1'b0, 0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    dataa = 32'h4280_0000;
    @(negedge clk);
    start = 1'b0;
    dataa = 32'hFFFF_FFFF;
    wait_done_cycle();
    issue(32'h4280_0000, 32'hE000_0000, 1'b0, 0, 1'b1);
    wait_idle(); @(negedge clk);

    // Clock-enable stall of 5 cycles while in SHIFT.
    issue(32'h437F_0000, 32'h3F80_0000, 1'b0, 5, 1'b1);
    @(posedge clk);
    #1 clk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1 clk_en = 1'b1;
    wait_idle(); @(negedge clk);

    // Leave saturated, nonzero outputs behind, then reset mid-conversion.
    issue(32'h447A_0000, 32'h7FFF_FFFF, 1'b1, 0, 1'b1);  // 1000.0
    wait_idle(); @(negedge clk);
    issue(32'h4280_0000, 32'h0, 1'b0, 0, 1'b0);
    #2 aclr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    aclr = 1'b1;
    repeat (10) @(negedge clk);

    issue(32'h0000_0000, 32'hC000_0000, 1'b0, 0, 1'b1);
    wait_idle();
    @(negedge clk);
    final_req = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
